// File: rtl/ysyx_2022040010_wb_arbiter.sv
// ysyx_2022040010_wb_arbiter
// Writeback arbiter: single-cycle ALU results (A) and buffered multi-cycle
// results (B, 2-entry FIFO) share the one regfile write port. The write
// port (we/waddr/wdata) is registered.
// Optional build macro: WB_STARVE_GUARD_EN enables an anti-starvation counter
// that forces a FIFO head write after STARVE_LIMIT consecutive A wins.
module ysyx_2022040010_wb_arbiter #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned AW           = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            we,
    output logic [AW-1:0]   waddr,
    output logic [XLEN-1:0] wdata,
    output logic [1:0]      b_cnt
);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_ent_t;

    wb_ent_t         fifo_mem [2];
    logic            wptr;
    logic            rptr;

    logic            a_fire;
    logic            b_push;
    logic            b_pop;
    logic            sel;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve;
    logic          starve_hit;

    // Starvation limit reached: refuse A so the FIFO head takes the port.
    assign starve_hit = (starve == SW'(STARVE_LIMIT));
    assign a_ready    = rst && !starve_hit;

    // Count consecutive A wins while B waits; any pop or empty FIFO clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (b_pop || (b_cnt == 2'd0)) begin
            starve <= '0;
        end else if (a_fire && !starve_hit) begin
            starve <= starve + SW'(1);
        end
    end
`else
    logic unused_starve_limit;

    // A always wins in the base build.
    assign a_ready             = rst;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    // B may push whenever the FIFO is not full; same-cycle pop is not credited.
    assign b_ready = rst && (b_cnt != 2'd2);

    // Per-cycle arbitration: A transfer first, else FIFO head, else idle.
    always_comb begin
        a_fire   = a_valid && a_ready;
        b_push   = b_valid && b_ready;
        b_pop    = 1'b0;
        sel      = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        if (a_fire) begin
            sel      = 1'b1;
            sel_rd   = a_rd;
            sel_data = a_data;
        end else if (b_cnt != 2'd0) begin
            b_pop    = 1'b1;
            sel      = 1'b1;
            sel_rd   = fifo_mem[rptr].rd;
            sel_data = fifo_mem[rptr].data;
        end
    end

    // FIFO storage; contents need no reset since b_cnt gates every read.
    always_ff @(posedge clk) begin
        if (b_push) begin
            fifo_mem[wptr] <= '{rd: b_rd, data: b_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            b_cnt <= 2'd0;
        end else begin
            if (b_push) begin
                wptr <= ~wptr;
            end
            if (b_pop) begin
                rptr <= ~rptr;
            end
            if (b_push && !b_pop) begin
                b_cnt <= b_cnt + 2'd1;
            end else if (b_pop && !b_push) begin
                b_cnt <= b_cnt - 2'd1;
            end
        end
    end

    // Registered regfile write port; x0 results are consumed without a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= sel && (sel_rd != '0);
            if (sel) begin
                waddr <= sel_rd;
                wdata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_wb_arbiter.sv
// Testbench for ysyx_2022040010_wb_arbiter: queue-based reference model
// compared every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_ysyx_2022040010_wb_arbiter;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned AW    = 5;
    localparam int unsigned LIMIT = 4;
    localparam int unsigned EW    = AW + XLEN;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, b_valid;
    logic            a_ready, b_ready;
    logic [AW-1:0]   a_rd, b_rd;
    logic [XLEN-1:0] a_data, b_data;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      b_cnt;

    int tests = 0;
    int fails = 0;

    // model state
    logic [EW-1:0]   q[$];
    logic            m_we;
    logic [AW-1:0]   m_waddr;
    logic [XLEN-1:0] m_wdata;
    int              m_starve;

    ysyx_2022040010_wb_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .we(we), .waddr(waddr), .wdata(wdata), .b_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compare();
        chk("we", XLEN'(we), XLEN'(m_we));
        chk("waddr", XLEN'(waddr), XLEN'(m_waddr));
        chk("wdata", wdata, m_wdata);
        chk("b_cnt", XLEN'(b_cnt), XLEN'(q.size()));
        chk("a_ready", XLEN'(a_ready), XLEN'(rst && !(GUARD && m_starve == int'(LIMIT))));
        chk("b_ready", XLEN'(b_ready), XLEN'(rst && q.size() != 2));
    endtask

    // Advance one clock: update the model from the current inputs, then check.
    task automatic tick();
        bit            a_fire, push, popped, sel;
        int            size0;
        logic [EW-1:0] ent;
        if (!rst) begin
            q.delete();
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_starve = 0;
        end else begin
            size0  = q.size();
            a_fire = a_valid && !(GUARD && m_starve == int'(LIMIT));
            push   = b_valid && (size0 != 2);
            popped = 1'b0;
            sel    = 1'b0;
            ent    = '0;
            if (a_fire) begin
                sel = 1'b1; ent = {a_rd, a_data};
            end else if (size0 != 0) begin
                sel = 1'b1; ent = q.pop_front(); popped = 1'b1;
            end
            if (GUARD) begin
                if (popped || size0 == 0) m_starve = 0;
                else if (a_fire) m_starve++;
            end
            if (push) q.push_back({b_rd, b_data});
            m_we = sel && (ent[EW-1:XLEN] != '0);
            if (sel) begin
                m_waddr = ent[EW-1:XLEN];
                m_wdata = ent[XLEN-1:0];
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic set_a(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        a_valid = v; a_rd = rd; a_data = d;
    endtask

    task automatic set_b(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        b_valid = v; b_rd = rd; b_data = d;
    endtask

    initial begin
        rst = 1'b0;
        set_a(1'b0, '0, '0);
        set_b(1'b0, '0, '0);
        q.delete();
        m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_starve = 0;
        #1;
        chk("rst_we", XLEN'(we), 0);
        chk("rst_bcnt", XLEN'(b_cnt), 0);
        chk("rst_a_ready", XLEN'(a_ready), 0);
        chk("rst_b_ready", XLEN'(b_ready), 0);
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_a_ready", XLEN'(a_ready), 1);
        chk("post_rst_b_ready", XLEN'(b_ready), 1);

        // A path
        set_a(1'b1, 5'd5, 64'h1234);
        tick();
        chk("a_we", XLEN'(we), 1);
        chk("a_waddr", XLEN'(waddr), 5);
        chk("a_wdata", wdata, 64'h1234);
        set_a(1'b0, '0, '0);
        tick();
        chk("a_we_drop", XLEN'(we), 0);

        // x0 drops
        set_a(1'b1, 5'd0, 64'hFFFF);
        tick();
        chk("a_x0_we", XLEN'(we), 0);
        set_a(1'b0, '0, '0);
        set_b(1'b1, 5'd0, 64'h55);
        tick();
        set_b(1'b0, '0, '0);
        tick();
        chk("b_x0_we", XLEN'(we), 0);
        chk("b_x0_cnt", XLEN'(b_cnt), 0);

        // B latency
        set_b(1'b1, 5'd7, 64'hAA);
        tick();
        chk("b_lat_we1", XLEN'(we), 0);
        set_b(1'b0, '0, '0);
        tick();
        chk("b_lat_we2", XLEN'(we), 1);
        chk("b_lat_waddr", XLEN'(waddr), 7);
        chk("b_lat_wdata", wdata, 64'hAA);

        // FIFO full with A busy, then ordered drain
        set_a(1'b1, 5'd1, 64'h11);
        set_b(1'b1, 5'd21, 64'h2100);
        tick();
        set_b(1'b1, 5'd22, 64'h2200);
        tick();
        chk("full_cnt", XLEN'(b_cnt), 2);
        chk("full_b_ready", XLEN'(b_ready), 0);
        set_b(1'b1, 5'd23, 64'h2300);
        tick();
        chk("stall_cnt", XLEN'(b_cnt), 2);
        set_a(1'b0, '0, '0);
        tick();
        chk("drain1", XLEN'(waddr), 21);
        tick();
        chk("drain2", XLEN'(waddr), 22);
        set_b(1'b0, '0, '0);
        tick();
        chk("drain3", XLEN'(waddr), 23);
        chk("drain3_data", wdata, 64'h2300);
        chk("drain_cnt", XLEN'(b_cnt), 0);

        // simultaneous push and pop
        set_a(1'b1, 5'd2, 64'h22);
        set_b(1'b1, 5'd9, 64'h99);
        tick();
        set_a(1'b0, '0, '0);
        set_b(1'b1, 5'd10, 64'h100);
        tick();
        chk("sim_cnt", XLEN'(b_cnt), 1);
        chk("sim_w1", XLEN'(waddr), 9);
        set_b(1'b0, '0, '0);
        tick();
        chk("sim_w2", XLEN'(waddr), 10);
        chk("sim_cnt0", XLEN'(b_cnt), 0);

        // starvation behaviour with one pending B entry
        set_a(1'b1, 5'd3, 64'h33);
        set_b(1'b1, 5'd12, 64'hC0);
        tick();
        set_b(1'b0, '0, '0);
`ifdef WB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) tick();
        chk("starve_a_ready", XLEN'(a_ready), 0);
        tick();
        chk("starve_waddr", XLEN'(waddr), 12);
        chk("starve_a_back", XLEN'(a_ready), 1);
`else
        for (int i = 0; i < 8; i++) tick();
        chk("nostarve_cnt", XLEN'(b_cnt), 1);
        chk("nostarve_waddr", XLEN'(waddr), 3);
`endif
        set_a(1'b0, '0, '0);
        tick();

        // async reset mid-traffic with a full FIFO
        set_a(1'b1, 5'd4, 64'h44);
        set_b(1'b1, 5'd13, 64'hD0);
        tick();
        set_b(1'b1, 5'd14, 64'hE0);
        tick();
        chk("pre_rst_cnt", XLEN'(b_cnt), 2);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_we", XLEN'(we), 0);
        chk("mid_rst_waddr", XLEN'(waddr), 0);
        chk("mid_rst_cnt", XLEN'(b_cnt), 0);
        chk("mid_rst_a_ready", XLEN'(a_ready), 0);
        chk("mid_rst_b_ready", XLEN'(b_ready), 0);
        @(negedge clk);
        tick();
        rst = 1'b1;
        set_a(1'b0, '0, '0);
        set_b(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_stale_we", XLEN'(we), 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int pa, pb;
            pa = (i < 1000) ? 30 : (i < 2000) ? 80 : 50;
            pb = (i < 1000) ? 60 : 50;
            set_a($urandom_range(0, 99) < pa, AW'($urandom_range(0, 31)), {$urandom(), $urandom()});
            set_b($urandom_range(0, 99) < pb, AW'($urandom_range(0, 31)), {$urandom(), $urandom()});
            rst = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
